// File: rtl/mdr_mem_if.sv
// Memory data register with its own request/acknowledge handshake to memory.
// Handles byte/half/word/dword lane alignment, sign/zero extension, alignment and timeout errors.
module mdr_mem_if #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int LANE_W  = $clog2(DATA_W/8)
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                MDRin,
  input  logic                Read,
  input  logic                Write,
  input  logic [1:0]          size,
  input  logic                sign_ext,
  input  logic [LANE_W-1:0]   addr_lo,
  input  logic [DATA_W-1:0]   BusMuxOut,
  input  logic [DATA_W-1:0]   Mdatain,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   Mdataout,
  output logic [DATA_W-1:0]   BusMuxIn_MDR,
  output logic                busy,
  output logic                done,
  output logic                align_err,
  output logic                timeout_err
);

  localparam int NB = DATA_W/8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_q;
  logic [7:0]          r_cnt;
  logic [1:0]          r_size;
  logic                r_sext;
  logic [LANE_W-1:0]   r_addr;
  logic                r_done;
  logic                r_align_err;
  logic                r_timeout_err;

  logic                w_legal;
  logic                w_start;
  logic                w_illegal;
  logic                w_load_bus;
  logic                w_finish;
  logic                w_abort;
  logic                w_ack_rd;
  logic [LANE_W+2:0]   w_shamt;
  logic [NB-1:0]       w_bmask;
  logic [DATA_W-1:0]   w_wmask;
  logic [DATA_W-1:0]   w_field;
  logic [DATA_W-1:0]   w_load;
  logic                w_sbit;

  assign w_shamt = {r_addr, 3'b000};

  // Unshifted byte mask of the latched access size, and its bit-level expansion.
  always_comb begin
    w_bmask = '0;
    for (int i = 0; i < NB; i++) w_bmask[i] = (i < (1 << r_size));
  end

  always_comb begin
    w_wmask = '0;
    for (int i = 0; i < NB; i++) w_wmask[8*i +: 8] = {8{w_bmask[i]}};
  end

  always_comb begin
    w_field = Mdatain >> w_shamt;
    case (r_size)
      2'b00:   w_sbit = w_field[7];
      2'b01:   w_sbit = w_field[15];
      2'b10:   w_sbit = w_field[31];
      default: w_sbit = w_field[DATA_W-1];
    endcase
    w_load = (w_field & w_wmask) | ((r_sext && w_sbit) ? ~w_wmask : '0);
  end

  always_comb begin
    w_legal = 1'b0;
    case (size)
      2'b00:   w_legal = 1'b1;
      2'b01:   w_legal = ~addr_lo[0];
      2'b10:   w_legal = (addr_lo[1:0] == 2'b00);
      default: w_legal = (DATA_W == 64) && (addr_lo == '0);
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_illegal  = 1'b0;
    w_load_bus = 1'b0;
    w_finish   = 1'b0;
    w_abort    = 1'b0;
    case (r_state)
      IDLE: begin
        if (Read || Write) begin
          if (!w_legal) begin
            w_illegal = 1'b1;
          end else begin
            w_start = 1'b1;
            w_next  = Read ? RD_WAIT : WR_WAIT;
          end
        end else if (MDRin) begin
          w_load_bus = 1'b1;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem_ack) begin
          w_finish = 1'b1;
          w_next   = IDLE;
        end else if (r_cnt == 8'(TIMEOUT-1)) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    w_ack_rd = w_finish && (r_state == RD_WAIT);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state       <= IDLE;
      r_q           <= '0;
      r_cnt         <= '0;
      r_size        <= '0;
      r_sext        <= 1'b0;
      r_addr        <= '0;
      r_done        <= 1'b0;
      r_align_err   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_illegal | w_finish | w_abort;
      if (w_illegal) r_align_err <= 1'b1;
      if (w_abort)   r_timeout_err <= 1'b1;
      if (w_start) begin
        r_align_err   <= 1'b0;
        r_timeout_err <= 1'b0;
        r_cnt         <= '0;
        r_size        <= size;
        r_sext        <= sign_ext;
        r_addr        <= addr_lo;
      end else if ((r_state != IDLE) && (w_next == r_state)) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_load_bus)    r_q <= BusMuxOut;
      else if (w_ack_rd) r_q <= w_load;
    end
  end

  assign busy         = (r_state != IDLE);
  assign mem_req      = busy;
  assign mem_we       = (r_state == WR_WAIT);
  assign mem_be       = busy ? (w_bmask << r_addr) : '0;
  // Write data comes from q, which cannot change while a write is pending.
  assign Mdataout     = mem_we ? ((r_q & w_wmask) << w_shamt) : '0;
  assign BusMuxIn_MDR = r_q;
  assign done         = r_done;
  assign align_err    = r_align_err;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_mdr_mem_if.sv
// Scoreboard bench for mdr_mem_if: 32-bit (TIMEOUT=4) and 64-bit (TIMEOUT=15) instances
// share stimulus; a monitor checks the selected instance at every done pulse.
module tb_mdr_mem_if;
  localparam int T32 = 4;
  localparam int T64 = 15;

  logic        clock;
  logic        clear;
  logic        MDRin, Read, Write, sign_ext, mem_ack;
  logic [1:0]  size;
  logic [2:0]  addr_lo;
  logic [63:0] BusMuxOut, Mdatain;

  logic        req32, we32, busy32, done32, aerr32, terr32;
  logic [3:0]  be32;
  logic [31:0] dout32, q32;
  logic        req64, we64, busy64, done64, aerr64, terr64;
  logic [7:0]  be64;
  logic [63:0] dout64, q64;

  bit          sel;
  logic        m_req, m_we, m_busy, m_done, m_aerr, m_terr;
  logic [7:0]  m_be;
  logic [63:0] m_dout, m_q;

  int num_checks = 0;
  int num_errors = 0;

  typedef struct {
    logic [63:0] q;
    bit          aerr;
    bit          terr;
    int          busy;
    bit          we;
    logic [7:0]  be;
    logic [63:0] dout;
  } exp_t;
  exp_t sbq[$];

  logic [63:0] mq;
  bit          maerr, mterr;

  mdr_mem_if #(.DATA_W(32), .TIMEOUT(T32)) dut32 (
    .clock(clock), .clear(clear), .MDRin(MDRin), .Read(Read), .Write(Write),
    .size(size), .sign_ext(sign_ext), .addr_lo(addr_lo[1:0]),
    .BusMuxOut(BusMuxOut[31:0]), .Mdatain(Mdatain[31:0]), .mem_ack(mem_ack),
    .mem_req(req32), .mem_we(we32), .mem_be(be32), .Mdataout(dout32),
    .BusMuxIn_MDR(q32), .busy(busy32), .done(done32),
    .align_err(aerr32), .timeout_err(terr32));

  mdr_mem_if #(.DATA_W(64), .TIMEOUT(T64)) dut64 (
    .clock(clock), .clear(clear), .MDRin(MDRin), .Read(Read), .Write(Write),
    .size(size), .sign_ext(sign_ext), .addr_lo(addr_lo),
    .BusMuxOut(BusMuxOut), .Mdatain(Mdatain), .mem_ack(mem_ack),
    .mem_req(req64), .mem_we(we64), .mem_be(be64), .Mdataout(dout64),
    .BusMuxIn_MDR(q64), .busy(busy64), .done(done64),
    .align_err(aerr64), .timeout_err(terr64));

  assign m_req  = sel ? req64  : req32;
  assign m_we   = sel ? we64   : we32;
  assign m_busy = sel ? busy64 : busy32;
  assign m_done = sel ? done64 : done32;
  assign m_aerr = sel ? aerr64 : aerr32;
  assign m_terr = sel ? terr64 : terr32;
  assign m_be   = sel ? be64   : {4'd0, be32};
  assign m_dout = sel ? dout64 : {32'd0, dout32};
  assign m_q    = sel ? q64    : {32'd0, q32};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] lowmask(input int nbits);
    if (nbits >= 64) return '1;
    return (64'd1 << nbits) - 64'd1;
  endfunction

  function automatic int width();
    return sel ? 64 : 32;
  endfunction

  task automatic scramble();
    size      = 2'($urandom_range(0, 3));
    addr_lo   = 3'($urandom_range(0, 7));
    sign_ext  = 1'($urandom_range(0, 1));
    BusMuxOut = {$urandom, $urandom};
    Mdatain   = {$urandom, $urandom};
  endtask

  task automatic load_mdr(input logic [63:0] v);
    @(negedge clock);
    MDRin = 1'b1;
    BusMuxOut = v;
    @(negedge clock);
    MDRin = 1'b0;
    mq = v & lowmask(width());
    chk("mdrin_load", m_q, mq);
  endtask

  // kind: 0 read, 1 write, 2 read+write together
  task automatic do_txn(input int kind, input int sz, input int addr, input bit sx,
                        input logic [63:0] mdata_in, input int delay);
    int W, T, nb, reqs;
    bit legal;
    exp_t e;
    logic [63:0] f, mdata;
    W = width();
    T = sel ? T64 : T32;
    nb = 1 << sz;
    mdata = mdata_in & lowmask(W);
    legal = (sz == 0) || (sz == 1 && addr % 2 == 0) || (sz == 2 && addr % 4 == 0) ||
            (sz == 3 && W == 64 && addr == 0);
    e.we = (kind == 1);
    e.be = '0;
    e.dout = '0;
    e.busy = 0;
    if (!legal) begin
      maerr = 1'b1;
    end else begin
      maerr = 1'b0;
      mterr = 1'b0;
      e.busy = (delay >= T) ? T : delay + 1;
      e.be = 8'(((1 << nb) - 1) << addr);
      if (kind == 1) e.dout = ((mq & lowmask(8*nb)) << (8*addr)) & lowmask(W);
      if (delay >= T) begin
        mterr = 1'b1;
      end else if (kind != 1) begin
        f = (mdata >> (8*addr)) & lowmask(8*nb);
        if (sx && (8*nb < W) && f[8*nb-1]) f = f | ~lowmask(8*nb);
        mq = f & lowmask(W);
      end
    end
    e.q = mq;
    e.aerr = maerr;
    e.terr = mterr;

    @(negedge clock);
    Read     = (kind != 1);
    Write    = (kind != 0);
    size     = 2'(sz);
    addr_lo  = 3'(addr);
    sign_ext = sx;
    MDRin    = 1'($urandom_range(0, 1));
    BusMuxOut = {$urandom, $urandom};
    mem_ack  = 1'b0;
    sbq.push_back(e);
    @(negedge clock);
    Read  = 1'b0;
    Write = 1'b0;
    MDRin = 1'b0;
    scramble();
    if (legal) begin
      reqs = (delay < T) ? delay : T;
      for (int i = 0; i < reqs; i++) begin
        MDRin = 1'b1;
        scramble();
        mem_ack = 1'b0;
        @(negedge clock);
      end
      if (delay < T) begin
        mem_ack = 1'b1;
        Mdatain = mdata_in;
        @(negedge clock);
      end
    end
    MDRin = 1'b0;
    mem_ack = 1'($urandom_range(0, 1));
    @(negedge clock);
    mem_ack = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    mq = '0;
    maerr = 1'b0;
    mterr = 1'b0;
  endtask

  task automatic rand_txns(input int n);
    int W, T;
    W = width();
    T = sel ? T64 : T32;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 4) == 0) load_mdr({$urandom, $urandom});
      do_txn($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, W/8 - 1),
             1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom_range(0, T + 1));
    end
  endtask

  // Monitor: counts request cycles, captures first-cycle lane outputs, checks at done.
  initial begin
    int bc, wt;
    bit prev_done;
    logic cap_we;
    logic [7:0] cap_be;
    logic [63:0] cap_dout;
    exp_t e;
    bc = 0; wt = 0; prev_done = 1'b0;
    cap_we = 1'b0; cap_be = '0; cap_dout = '0;
    forever begin
      @(negedge clock);
      if (!clear) begin
        bc = 0; wt = 0; prev_done = 1'b0;
      end else begin
        if (m_req) begin
          if (bc == 0) begin
            cap_we = m_we; cap_be = m_be; cap_dout = m_dout;
          end
          bc++;
        end
        if (m_done) begin
          chk("done_single_cycle", 64'(prev_done), 64'd0);
          if (sbq.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = sbq.pop_front();
            chk("q", m_q, e.q);
            chk("align_err", 64'(m_aerr), 64'(e.aerr));
            chk("timeout_err", 64'(m_terr), 64'(e.terr));
            chk("req_cycles", 64'(bc), 64'(e.busy));
            chk("busy_at_done", 64'(m_busy), 64'd0);
            if (e.busy > 0) begin
              chk("mem_we", 64'(cap_we), 64'(e.we));
              chk("mem_be", 64'(cap_be), 64'(e.be));
              chk("Mdataout", cap_dout, e.dout);
            end
          end
          bc = 0; wt = 0;
        end else if (sbq.size() > 0) begin
          wt++;
          if (wt > 200) begin
            chk("done_timeout", 64'd0, 64'd1);
            void'(sbq.pop_front());
            wt = 0; bc = 0;
          end
        end
        prev_done = m_done;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bound;
    sel = 1'b0;
    clear = 1'b0;
    MDRin = 1'b0; Read = 1'b0; Write = 1'b0; mem_ack = 1'b0;
    size = '0; sign_ext = 1'b0; addr_lo = '0; BusMuxOut = '0; Mdatain = '0;
    mq = '0; maerr = 1'b0; mterr = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_q", m_q, 64'd0);
    chk("rst_req", 64'(m_req), 64'd0);
    chk("rst_busy", 64'(m_busy), 64'd0);
    chk("rst_done", 64'(m_done), 64'd0);
    chk("rst_flags", {62'd0, m_aerr, m_terr}, 64'd0);
    chk("rst_be_we", {55'd0, m_we, m_be}, 64'd0);
    chk("rst_dout", m_dout, 64'd0);
    clear = 1'b1;

    load_mdr(64'h12345678);
    do_txn(0, 0, 1, 1'b1, 64'h0000F300, 2);
    do_txn(0, 0, 1, 1'b0, 64'h0000F300, 2);
    load_mdr(64'h0000ABCD);
    do_txn(1, 1, 2, 1'b0, 64'h0, 1);
    do_txn(0, 2, 2, 1'b0, 64'h55AA55AA, 0);
    do_txn(0, 2, 0, 1'b0, 64'h11223344, 0);
    do_txn(0, 0, 0, 1'b0, 64'h0, 10);
    do_txn(2, 2, 0, 1'b0, 64'hCAFEF00D, 1);
    do_txn(0, 3, 0, 1'b0, 64'h1, 0);
    do_txn(0, 1, 2, 1'b1, 64'h8001_0000, 3);
    rand_txns(50);

    // Asynchronous reset in the middle of a read wait
    load_mdr(64'hDEADBEEF);
    @(negedge clock);
    Read = 1'b1; size = 2'b00; addr_lo = 3'd1; sign_ext = 1'b0; mem_ack = 1'b0;
    @(negedge clock);
    Read = 1'b0;
    repeat (3) @(negedge clock);
    chk("pre_rst_req", 64'(m_req), 64'd1);
    #3;
    clear = 1'b0;
    #1;
    chk("async_rst_req", 64'(m_req), 64'd0);
    chk("async_rst_busy", 64'(m_busy), 64'd0);
    chk("async_rst_q", m_q, 64'd0);
    @(negedge clock);
    clear = 1'b1;
    mq = '0; maerr = 1'b0; mterr = 1'b0;
    MDRin = 1'b1;
    BusMuxOut = 64'h0BADF00D;
    @(negedge clock);
    MDRin = 1'b0;
    mq = 64'h0BADF00D;
    chk("mdrin_after_rst", m_q, mq);
    chk("idle_after_rst", 64'(m_busy), 64'd0);

    sel = 1'b1;
    do_reset();
    do_txn(0, 3, 0, 1'b0, 64'h8000000000000001, 0);
    do_txn(1, 3, 0, 1'b0, 64'h0, 2);
    do_txn(0, 2, 4, 1'b1, 64'h9000_0000_0000_0000, 1);
    do_txn(0, 3, 4, 1'b0, 64'h1, 0);
    do_txn(0, 0, 0, 1'b0, 64'h0, 20);
    rand_txns(50);

    bound = 0;
    while (sbq.size() > 0 && bound < 500) begin
      @(negedge clock);
      bound++;
    end
    if (sbq.size() > 0) chk("scoreboard_drain", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end
endmodule
